// File: rtl/nanosoc_busmatrix_pkg.sv
// rtl/nanosoc_busmatrix_pkg.sv - shared AHB encodings and input-stage state type
package nanosoc_busmatrix_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // trans + write + size + burst + prot, excluding address and lock
    localparam int HOLD_CTRL_W = 13;

    typedef enum logic [1:0] {
        INSTAGE_IDLE = 2'd0,
        INSTAGE_PEND = 2'd1,
        INSTAGE_DATA = 2'd2
    } instage_state_e;

endpackage

// File: rtl/nanosoc_busmatrix_addr_hold_reg.sv
// rtl/nanosoc_busmatrix_addr_hold_reg.sv - load-enabled address-phase hold register
// Lock bit stored only when NANOSOC_INSTAGE_LOCK_EN is defined.
module nanosoc_busmatrix_addr_hold_reg
    import nanosoc_busmatrix_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]            trans_i,
    input  logic                  write_i,
    input  logic [2:0]            size_i,
    input  logic [2:0]            burst_i,
    input  logic [3:0]            prot_i,
    input  logic                  lock_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [1:0]            trans_o,
    output logic                  write_o,
    output logic [2:0]            size_o,
    output logic [2:0]            burst_o,
    output logic [3:0]            prot_o,
    output logic                  lock_o
);

    localparam int BASE_W = ADDR_WIDTH + HOLD_CTRL_W;

`ifdef NANOSOC_INSTAGE_LOCK_EN
    localparam int HOLD_W = BASE_W + 1;
    logic [HOLD_W-1:0] hold_d;
    logic [HOLD_W-1:0] hold_q;

    assign hold_d = {lock_i, addr_i, trans_i, write_i, size_i, burst_i, prot_i};
    assign lock_o = hold_q[HOLD_W-1];
`else
    localparam int HOLD_W = BASE_W;
    logic [HOLD_W-1:0] hold_d;
    logic [HOLD_W-1:0] hold_q;
    logic              unused_lock;

    assign hold_d      = {addr_i, trans_i, write_i, size_i, burst_i, prot_i};
    assign lock_o      = 1'b0;
    assign unused_lock = lock_i;
`endif

    assign {addr_o, trans_o, write_o, size_o, burst_o, prot_o} = hold_q[BASE_W-1:0];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_q <= '0;
        end else if (load_i) begin
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/nanosoc_busmatrix_input_stage.sv
// rtl/nanosoc_busmatrix_input_stage.sv - per-master AHB-Lite bus matrix input stage
// Optional lock forwarding via NANOSOC_INSTAGE_LOCK_EN.
module nanosoc_busmatrix_input_stage
    import nanosoc_busmatrix_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    output logic                  sel_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [1:0]            trans_out,
    output logic                  write_out,
    output logic [2:0]            size_out,
    output logic [2:0]            burst_out,
    output logic [3:0]            prot_out,
    output logic                  lock_out,
    output logic                  held_out,
    input  logic                  active_in,
    input  logic                  data_ready_in,
    input  logic                  data_resp_in
);

    instage_state_e state_q;

    logic                  live_valid;
    logic                  addr_cycle;
    logic                  hold_load;
    logic                  in_pend;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [1:0]            hold_trans;
    logic                  hold_write;
    logic [2:0]            hold_size;
    logic [2:0]            hold_burst;
    logic [3:0]            hold_prot;
    logic                  hold_lock;

    // IDLE/BUSY never occupy a slave, so they are never held
    assign live_valid = HSELS & HTRANSS[1] & HREADYS;
    assign addr_cycle = (state_q == INSTAGE_IDLE) |
                        ((state_q == INSTAGE_DATA) & data_ready_in);
    assign hold_load  = addr_cycle & live_valid & ~active_in;
    assign in_pend    = (state_q == INSTAGE_PEND);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= INSTAGE_IDLE;
        end else begin
            case (state_q)
                INSTAGE_PEND: begin
                    if (active_in) begin
                        state_q <= INSTAGE_DATA;
                    end
                end
                default: begin
                    if (addr_cycle) begin
                        if (!live_valid) begin
                            state_q <= INSTAGE_IDLE;
                        end else if (active_in) begin
                            state_q <= INSTAGE_DATA;
                        end else begin
                            state_q <= INSTAGE_PEND;
                        end
                    end
                end
            endcase
        end
    end

    nanosoc_busmatrix_addr_hold_reg #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hold (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .load_i  (hold_load),
        .addr_i  (HADDRS),
        .trans_i (HTRANSS),
        .write_i (HWRITES),
        .size_i  (HSIZES),
        .burst_i (HBURSTS),
        .prot_i  (HPROTS),
        .lock_i  (HMASTLOCKS),
        .addr_o  (hold_addr),
        .trans_o (hold_trans),
        .write_o (hold_write),
        .size_o  (hold_size),
        .burst_o (hold_burst),
        .prot_o  (hold_prot),
        .lock_o  (hold_lock)
    );

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = HRESP_OKAY;
        case (state_q)
            INSTAGE_PEND: HREADYOUTS = 1'b0;
            INSTAGE_DATA: begin
                HREADYOUTS = data_ready_in;
                HRESPS     = data_resp_in;
            end
            default: ;
        endcase
    end

    assign sel_out   = live_valid | in_pend;
    assign held_out  = in_pend;
    assign addr_out  = in_pend ? hold_addr  : HADDRS;
    assign trans_out = in_pend ? hold_trans : HTRANSS;
    assign write_out = in_pend ? hold_write : HWRITES;
    assign size_out  = in_pend ? hold_size  : HSIZES;
    assign burst_out = in_pend ? hold_burst : HBURSTS;
    assign prot_out  = in_pend ? hold_prot  : HPROTS;

`ifdef NANOSOC_INSTAGE_LOCK_EN
    assign lock_out = in_pend ? hold_lock : HMASTLOCKS;
`else
    logic unused_hold_lock;
    assign unused_hold_lock = hold_lock;
    assign lock_out         = 1'b0;
`endif

endmodule

// File: tb/tb_nanosoc_busmatrix_input_stage.sv
// tb/tb_nanosoc_busmatrix_input_stage.sv - directed and randomized bench for the input stage
module tb_nanosoc_busmatrix_input_stage;
    import nanosoc_busmatrix_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic        sel_out;
    logic [31:0] addr_out;
    logic [1:0]  trans_out;
    logic        write_out;
    logic [2:0]  size_out;
    logic [2:0]  burst_out;
    logic [3:0]  prot_out;
    logic        lock_out;
    logic        held_out;
    logic        active_in;
    logic        data_ready_in;
    logic        data_resp_in;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 HCLK = ~HCLK;

    nanosoc_busmatrix_input_stage #(.ADDR_WIDTH(32)) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .HSELS         (HSELS),
        .HADDRS        (HADDRS),
        .HTRANSS       (HTRANSS),
        .HWRITES       (HWRITES),
        .HSIZES        (HSIZES),
        .HBURSTS       (HBURSTS),
        .HPROTS        (HPROTS),
        .HMASTLOCKS    (HMASTLOCKS),
        .HREADYS       (HREADYS),
        .HREADYOUTS    (HREADYOUTS),
        .HRESPS        (HRESPS),
        .sel_out       (sel_out),
        .addr_out      (addr_out),
        .trans_out     (trans_out),
        .write_out     (write_out),
        .size_out      (size_out),
        .burst_out     (burst_out),
        .prot_out      (prot_out),
        .lock_out      (lock_out),
        .held_out      (held_out),
        .active_in     (active_in),
        .data_ready_in (data_ready_in),
        .data_resp_in  (data_resp_in)
    );

    // Reference model: a transfer waiting for grant, and an owed data phase
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
    } xfer_t;

    bit    m_wait;
    bit    m_owed;
    xfer_t m_hold;

    function automatic xfer_t live_xfer();
        return {HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS};
    endfunction

    function automatic logic exp_ready();
        if (m_wait) return 1'b0;
        if (m_owed) return data_ready_in;
        return 1'b1;
    endfunction

    function automatic logic exp_resp();
        if (!m_wait && m_owed) return data_resp_in;
        return 1'b0;
    endfunction

    task automatic model_advance();
        logic  live;
        bit    nw;
        bit    no;
        xfer_t nh;
        live = HSELS && HTRANSS[1] && HREADYS;
        nw = m_wait;
        no = m_owed;
        nh = m_hold;
        if (m_wait) begin
            if (active_in) begin
                nw = 0;
                no = 1;
            end
        end else if (!m_owed || data_ready_in) begin
            if (!live) begin
                no = 0;
            end else if (active_in) begin
                no = 1;
            end else begin
                nw = 1;
                no = 0;
                nh = live_xfer();
            end
        end
        @(posedge HCLK);
        m_wait = nw;
        m_owed = no;
        m_hold = nh;
        @(negedge HCLK);
    endtask

    task automatic drive_idle();
        HSELS         = 1'b0;
        HADDRS        = 32'h0;
        HTRANSS       = HTRANS_IDLE;
        HWRITES       = 1'b0;
        HSIZES        = 3'd0;
        HBURSTS       = HBURST_SINGLE;
        HPROTS        = 4'd0;
        HMASTLOCKS    = 1'b0;
        HREADYS       = 1'b1;
        active_in     = 1'b0;
        data_ready_in = 1'b1;
        data_resp_in  = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic test_reset();
        drive_idle();
        HRESETn = 1'b0;
        next_cycle();
        next_cycle();
        HRESETn = 1'b1;
        next_cycle();
        #1;
        n_tests++;
        if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", HREADYOUTS); end
        n_tests++;
        if (HRESPS !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 0", HRESPS); end
        n_tests++;
        if (sel_out !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b want 0", sel_out); end
        n_tests++;
        if (held_out !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b want 0", held_out); end
    endtask

    task automatic test_granted();
        logic [2:0] rdy_seq;
        rdy_seq = 3'b100;
        drive_idle();
        HSELS   = 1'b1;
        HTRANSS = HTRANS_NONSEQ;
        HADDRS  = 32'h0000_1000;
        active_in = 1'b1;
        #1;
        n_tests++;
        if (addr_out !== 32'h0000_1000) begin n_fail++; $display("FAIL grant_addr: got %h want 00001000", addr_out); end
        n_tests++;
        if (sel_out !== 1'b1 || held_out !== 1'b0) begin
            n_fail++; $display("FAIL grant_sel_held: got sel=%b held=%b want 1/0", sel_out, held_out);
        end
        n_tests++;
        if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL grant_ready_addr: got %b want 1", HREADYOUTS); end
        next_cycle();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            data_ready_in = rdy_seq[i];
            HREADYS       = rdy_seq[i];
            #1;
            n_tests++;
            if (HREADYOUTS !== rdy_seq[i]) begin
                n_fail++; $display("FAIL grant_data_ready[%0d]: got %b want %b", i, HREADYOUTS, rdy_seq[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_pend();
        drive_idle();
        HSELS   = 1'b1;
        HTRANSS = HTRANS_NONSEQ;
        HADDRS  = 32'h0000_2000;
        HWRITES = 1'b1;
        HSIZES  = 3'd2;
        #1;
        n_tests++;
        if (HREADYOUTS !== 1'b1 || held_out !== 1'b0) begin
            n_fail++; $display("FAIL pend_addr_cycle: got ready=%b held=%b want 1/0", HREADYOUTS, held_out);
        end
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            HADDRS    = $urandom;
            HTRANSS   = 2'($urandom_range(0, 3));
            HWRITES   = 1'b0;
            HSIZES    = 3'd0;
            HREADYS   = 1'b0;
            active_in = (k == 2);
            #1;
            n_tests++;
            if (HREADYOUTS !== 1'b0) begin n_fail++; $display("FAIL pend_ready[%0d]: got %b want 0", k, HREADYOUTS); end
            n_tests++;
            if (held_out !== 1'b1 || sel_out !== 1'b1) begin
                n_fail++; $display("FAIL pend_held_sel[%0d]: got held=%b sel=%b want 1/1", k, held_out, sel_out);
            end
            n_tests++;
            if (addr_out !== 32'h0000_2000 || write_out !== 1'b1 || size_out !== 3'd2 || trans_out !== HTRANS_NONSEQ) begin
                n_fail++; $display("FAIL pend_fields[%0d]: got addr=%h w=%b sz=%0d tr=%0d want 00002000/1/2/2",
                                   k, addr_out, write_out, size_out, trans_out);
            end
            next_cycle();
        end
        drive_idle();
        data_ready_in = 1'b1;
        #1;
        n_tests++;
        if (HREADYOUTS !== 1'b1 || held_out !== 1'b0) begin
            n_fail++; $display("FAIL pend_data_phase: got ready=%b held=%b want 1/0", HREADYOUTS, held_out);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [1:0] tr;
        drive_idle();
        HSELS     = 1'b1;
        HBURSTS   = HBURST_INCR4;
        active_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tr      = (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            HTRANSS = tr;
            HADDRS  = 32'h0000_3000 + 32'(4 * i);
            #1;
            n_tests++;
            if (HREADYOUTS !== 1'b1 || held_out !== 1'b0) begin
                n_fail++; $display("FAIL b2b_ready[%0d]: got ready=%b held=%b want 1/0", i, HREADYOUTS, held_out);
            end
            n_tests++;
            if (trans_out !== tr || addr_out !== 32'h0000_3000 + 32'(4 * i) || burst_out !== HBURST_INCR4) begin
                n_fail++; $display("FAIL b2b_trans[%0d]: got tr=%0d addr=%h burst=%0d want %0d", i, trans_out, addr_out, burst_out, tr);
            end
            next_cycle();
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_error();
        drive_idle();
        HSELS     = 1'b1;
        HTRANSS   = HTRANS_NONSEQ;
        HADDRS    = 32'h0000_0040;
        active_in = 1'b1;
        next_cycle();
        drive_idle();
        data_ready_in = 1'b0;
        data_resp_in  = 1'b1;
        HREADYS       = 1'b0;
        #1;
        n_tests++;
        if (HRESPS !== 1'b1 || HREADYOUTS !== 1'b0) begin
            n_fail++; $display("FAIL err_cycle1: got resp=%b ready=%b want 1/0", HRESPS, HREADYOUTS);
        end
        next_cycle();
        data_ready_in = 1'b1;
        HREADYS       = 1'b1;
        HSELS         = 1'b1;
        HTRANSS       = HTRANS_NONSEQ;
        HADDRS        = 32'h0000_4000;
        active_in     = 1'b0;
        #1;
        n_tests++;
        if (HRESPS !== 1'b1 || HREADYOUTS !== 1'b1) begin
            n_fail++; $display("FAIL err_cycle2: got resp=%b ready=%b want 1/1", HRESPS, HREADYOUTS);
        end
        next_cycle();
        drive_idle();
        HREADYS   = 1'b0;
        active_in = 1'b1;
        #1;
        n_tests++;
        if (held_out !== 1'b1 || addr_out !== 32'h0000_4000 || HRESPS !== 1'b0 || HREADYOUTS !== 1'b0) begin
            n_fail++; $display("FAIL err_next_addr: got held=%b addr=%h resp=%b ready=%b want 1/00004000/0/0",
                               held_out, addr_out, HRESPS, HREADYOUTS);
        end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    task automatic test_ignore_active();
        drive_idle();
        active_in     = 1'b1;
        data_ready_in = 1'b0;
        #1;
        n_tests++;
        if (sel_out !== 1'b0) begin n_fail++; $display("FAIL ign_sel_idle: got %b want 0", sel_out); end
        next_cycle();
        HSELS   = 1'b1;
        HTRANSS = HTRANS_BUSY;
        #1;
        n_tests++;
        if (HREADYOUTS !== 1'b1 || sel_out !== 1'b0) begin
            n_fail++; $display("FAIL ign_busy: got ready=%b sel=%b want 1/0", HREADYOUTS, sel_out);
        end
        next_cycle();
        #1;
        n_tests++;
        if (HREADYOUTS !== 1'b1) begin n_fail++; $display("FAIL ign_still_idle: got %b want 1", HREADYOUTS); end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_reset_pend();
        drive_idle();
        HSELS      = 1'b1;
        HTRANSS    = HTRANS_NONSEQ;
        HADDRS     = 32'h0000_5000;
        HMASTLOCKS = 1'b1;
        next_cycle();
        HREADYS = 1'b0;
        #1;
        n_tests++;
        if (held_out !== 1'b1 || lock_out !== 1'b0) begin
            n_fail++; $display("FAIL rstp_in_pend: got held=%b lock=%b want 1/0", held_out, lock_out);
        end
        HSELS   = 1'b0;
        HRESETn = 1'b0;
        #1;
        n_tests++;
        if (HREADYOUTS !== 1'b1 || sel_out !== 1'b0 || held_out !== 1'b0) begin
            n_fail++; $display("FAIL rstp_async: got ready=%b sel=%b held=%b want 1/0/0", HREADYOUTS, sel_out, held_out);
        end
        next_cycle();
        HRESETn = 1'b1;
        HREADYS = 1'b1;
        #1;
        n_tests++;
        if (HREADYOUTS !== 1'b1 || sel_out !== 1'b0 || held_out !== 1'b0) begin
            n_fail++; $display("FAIL rstp_next: got ready=%b sel=%b held=%b want 1/0/0", HREADYOUTS, sel_out, held_out);
        end
        HSELS     = 1'b1;
        active_in = 1'b1;
        #1;
        n_tests++;
        if (lock_out !== 1'b0 || sel_out !== 1'b1) begin
            n_fail++; $display("FAIL rstp_lock_live: got lock=%b sel=%b want 0/1", lock_out, sel_out);
        end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    task automatic test_random();
        xfer_t exp_x;
        logic  exp_live;
        drive_idle();
        HRESETn = 1'b0;
        next_cycle();
        HRESETn = 1'b1;
        m_wait = 0;
        m_owed = 0;
        m_hold = '0;
        for (int i = 0; i < 400; i++) begin
            HSELS         = ($urandom_range(0, 3) != 0);
            HTRANSS       = 2'($urandom_range(0, 3));
            HADDRS        = $urandom;
            HWRITES       = 1'($urandom_range(0, 1));
            HSIZES        = 3'($urandom_range(0, 7));
            HBURSTS       = 3'($urandom_range(0, 7));
            HPROTS        = 4'($urandom_range(0, 15));
            HMASTLOCKS    = 1'($urandom_range(0, 1));
            active_in     = 1'($urandom_range(0, 1));
            data_ready_in = ($urandom_range(0, 3) != 0);
            data_resp_in  = ($urandom_range(0, 7) == 0);
            HREADYS       = exp_ready();
            #1;
            exp_live = HSELS && HTRANSS[1] && HREADYS;
            exp_x    = m_wait ? m_hold : live_xfer();
            n_tests++;
            if ({addr_out, trans_out, write_out, size_out, burst_out, prot_out} !== exp_x) begin
                n_fail++; $display("FAIL rnd_fields[%0d]: got %h want %h", i,
                                   {addr_out, trans_out, write_out, size_out, burst_out, prot_out}, exp_x);
            end
            n_tests++;
            if (HREADYOUTS !== exp_ready() || HRESPS !== exp_resp()) begin
                n_fail++; $display("FAIL rnd_resp[%0d]: got ready=%b resp=%b want %b/%b", i,
                                   HREADYOUTS, HRESPS, exp_ready(), exp_resp());
            end
            n_tests++;
            if (sel_out !== (exp_live | m_wait) || held_out !== m_wait || lock_out !== 1'b0) begin
                n_fail++; $display("FAIL rnd_sel[%0d]: got sel=%b held=%b lock=%b want %b/%b/0", i,
                                   sel_out, held_out, lock_out, exp_live | m_wait, m_wait);
            end
            model_advance();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        HRESETn = 1'b0;
        @(negedge HCLK);
        test_reset();
        test_granted();
        test_pend();
        test_back_to_back();
        test_error();
        test_ignore_active();
        test_reset_pend();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
